perip_bridge: RTL and testbench
===============================

# perip_bridge

Responder end of the CPU data-side peripheral bus. It decodes `perip_addr`, services byte, halfword and word stores into a data RAM and a small MMIO register file, and returns read data combinationally so a single-cycle core can load in the same cycle. It sits between the CPU top and the board I/O: switches, LEDs, an 8-digit seven-segment display and a free-running cycle counter.

## Interface
- `DRAM_AW`, 14: word-address bits of data RAM (2^14 words = 64 KiB).
- `SCAN_DIV`, 50000: clock cycles per seven-segment digit slot; legal range is ≥ 2.
- `clk` in 1: the only clock; every register updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-high. The top-level name is kept; reset is asserted when the signal is 1.
- `perip_addr` in 32: byte address from the CPU.
- `perip_wdata` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `perip_wen` in 1: store strobe, sampled at the clock edge.
- `perip_mask` in 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = reserved (store ignored).
- `perip_rdata` out 32: aligned word at `perip_addr & ~3`, combinational.
- `sw` in 24: board switches, read-only.
- `led` out 24: LED register.
- `seg_an` out 8: digit enables, active-low, one-hot.
- `seg_cx` out 8: segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Address map. Any address not listed reads 0, and stores to it are ignored.
  - DRAM: 0x8010_0000 to 0x8010_0000 + 4·2^DRAM_AW − 1.
  - 0x8020_0000 `SW`: RO, returns {8'b0, sw}.
  - 0x8020_0020 `SEG`: RW, 8 hex nibbles; nibble 0 drives digit 0 (rightmost).
  - 0x8020_0040 `LED`: RW; only bits [23:0] are stored, and reads return upper bits 0.
  - 0x8020_0050 `CNT`: RO, 32-bit cycle count.
  - 0x8020_0060 `CNT_CTL`: WO, reads 0.
- Store lane steering:
  - Byte: lane `addr[1:0]`.
  - Halfword: lanes `{addr[1],0}` and `{addr[1],1}`.
  - Word: all four lanes.
- Misaligned stores are dropped and leave no state change: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- MMIO registers accept word stores only. Byte and halfword stores to MMIO are ignored.
- Loads always return the full aligned word. Sign and zero extension and lane extraction are done in the CPU.
- `CNT_CTL` commands:
  - 0x8000_0000: clear `CNT` to 0 and start counting.
  - 0xFFFF_FFFF: stop and hold `CNT`.
  - Any other value is ignored.
- While running, `CNT` increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- Seven-segment scan:
  - A divider counts 0..SCAN_DIV−1. On wrap the digit index advances 0→7→0.
  - `seg_an` = ~(1<<index).
  - `seg_cx` = active-low hex glyph of `SEG[4·index+3 : 4·index]`; dp is always off (bit 7 = 1).

## Timing
- Read latency is 0 cycles: `perip_rdata` is a combinational function of `perip_addr` and the current register and RAM contents.
- Stores commit at the clock edge where `perip_wen`=1. A load of the same address in that cycle returns the old value; the new value is visible from the next cycle.
- Reset values:
  - `led`=0, `SEG`=0.
  - `CNT`=0, stopped.
  - Divider=0, index=0.
  - `seg_an`=8'hFE, `seg_cx`=8'hC0 (glyph "0").
  - DRAM contents are not reset.
- Reset asserted mid-operation overrides any concurrent store or `CNT_CTL` command in that cycle.
- Start command while already running: `CNT` is 0 on the next cycle, then continues counting.
- `CNT` read during the command cycle returns the pre-edge value.
- `seg_an`/`seg_cx` are registered and change 1 cycle after the index advances, so each digit is held exactly SCAN_DIV cycles.
- A write to `SEG` reaches the display within one scan slot.

## Configuration
- `PERIP_CNT_EN` defined: `CNT` and `CNT_CTL` are present as specified above.
- `PERIP_CNT_EN` undefined: the counter logic is removed. `CNT` reads 0 and `CNT_CTL` stores are ignored; both addresses behave as unmapped.

## Structure
- Shared package/header `perip_define.v` holds:
  - Base addresses and register offsets.
  - `perip_mask` encodings.
  - `CNT_CTL` command constants.
  - The 16-entry hex-to-segment glyph table.
- Sub-module `seg7_scan` contains the divider, the digit index and the registered `seg_an`/`seg_cx`. Its input is the 32-bit `SEG` value and it is parameterised by `SCAN_DIV`.
- DRAM is implemented as a byte-lane-writable array of 2^DRAM_AW words.

## Test plan
- Reset, then read 0x8020_0000 with `sw`=24'hA5A5A5 → `perip_rdata`=0x00A5A5A5; `led`=0; `seg_an`=8'hFE; `seg_cx`=8'hC0.
- Word store 0x1122_3344 @0x8010_0010, then byte store 0xEE @0x8010_0011, then halfword store 0xBEEF @0x8010_0012 → read of 0x8010_0010 = 0xBEEF_EE44.
- Halfword store @0x8010_0011 and word store @0x8010_0012 → word stays 0xBEEF_EE44. Store and read @0x8030_0000 → read returns 0, no state change.
- `CNT_CTL` ← 0x8000_0000, wait 100 cycles, then `CNT_CTL` ← 0xFFFF_FFFF → `CNT` holds 100 (±1 per the documented edge) and holds constant over the next 50 cycles. With `PERIP_CNT_EN` undefined, the same sequence reads 0.
- `SEG` ← 0x0123_4567 with `SCAN_DIV`=4 → `seg_an` steps FE, FD, …, 7F every 4 cycles. `seg_cx` shows 7 (F8), 6 (82), …, 0 (C0) and wraps to digit 0.
- Assert `rst_n` in the same cycle as `LED` ← 0xFFFFFF → `led` stays 0 after release.

Source files
------------

// File: rtl/perip_bridge_pkg.sv
// perip_bridge_pkg: shared constants for the data-side peripheral bridge.
//   - Base addresses of DRAM and the MMIO registers.
//   - perip_mask access-size encodings.
//   - CNT_CTL command words.
//   - Hex-to-seven-segment glyph table.
//   - Helpers for store byte-lane enables and write-data replication.
package perip_bridge_pkg;

  localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
  localparam logic [31:0] SW_ADDR   = 32'h8020_0000;
  localparam logic [31:0] SEG_ADDR  = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR  = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR  = 32'h8020_0050;
  localparam logic [31:0] CTL_ADDR  = 32'h8020_0060;

  localparam logic [31:0] CNT_CMD_START = 32'h8000_0000;
  localparam logic [31:0] CNT_CMD_STOP  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10,
    MASK_RSVD = 2'b11
  } mask_e;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Byte-lane enables for a store; misaligned and reserved sizes yield no lanes,
  // which is what drops them without any state change.
  function automatic logic [3:0] store_lanes(input mask_e mask, input logic [1:0] lo);
    logic [3:0] be;
    case (mask)
      MASK_BYTE: be = 4'b0001 << lo;
      MASK_HALF: be = lo[0] ? 4'b0000 : (lo[1] ? 4'b1100 : 4'b0011);
      MASK_WORD: be = (lo == 2'b00) ? 4'b1111 : 4'b0000;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data copied onto every lane so any enabled lane sees it.
  function automatic logic [31:0] store_data(input mask_e mask, input logic [31:0] wd);
    logic [31:0] d;
    case (mask)
      MASK_BYTE: d = {4{wd[7:0]}};
      MASK_HALF: d = {2{wd[15:0]}};
      default:   d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/perip_bridge_if.sv
// perip_bridge_if: CPU data-side peripheral bus.
//   perip_addr  32  byte address
//   perip_wdata 32  right-aligned store data
//   perip_wen    1  store strobe
//   perip_mask   2  access size (byte/half/word/reserved)
//   perip_rdata 32  aligned read word, combinational from the responder
// Modports: master (CPU side), slave (bridge side).
interface perip_bridge_if;
  logic [31:0] perip_addr;
  logic [31:0] perip_wdata;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_rdata;

  modport master (output perip_addr, output perip_wdata, output perip_wen,
                  output perip_mask, input perip_rdata);
  modport slave  (input perip_addr, input perip_wdata, input perip_wen,
                  input perip_mask, output perip_rdata);
endinterface

// File: rtl/perip_bridge_seg7_scan.sv
// perip_bridge_seg7_scan: multiplexed scan of an 8-digit seven-segment display.
//   clk        in   clock
//   rst_n      in   synchronous reset, active-high
//   seg_val    in   8 hex nibbles, nibble 0 = rightmost digit
//   seg_an     out  digit enables, active-low one-hot (registered)
//   seg_cx     out  segments {dp,g,f,e,d,c,b,a}, active-low (registered)
// Parameter SCAN_DIV: clock cycles per digit slot (>= 2).
module perip_bridge_seg7_scan
  import perip_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seg_val,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cx
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;

  // Outputs follow idx one cycle late, so every digit is held a full slot.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      div    <= '0;
      idx    <= '0;
      seg_an <= 8'hFE;
      seg_cx <= 8'hC0;
    end else begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= idx + 3'd1;
      end else begin
        div <= div + 1'b1;
      end
      seg_an <= ~(8'd1 << idx);
      seg_cx <= seg_glyph(seg_val[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/perip_bridge.sv
// perip_bridge: responder end of the CPU data-side peripheral bus.
//   clk      in   clock
//   rst_n    in   synchronous reset, active-high (asserted when 1)
//   bus      slave modport of perip_bridge_if
//   sw       in   24 board switches
//   led      out  24 LED register
//   seg_an   out  8 digit enables, active-low
//   seg_cx   out  8 segments, active-low
// Parameters: DRAM_AW (word-address bits of data RAM), SCAN_DIV (cycles per digit).
// Optional: define PERIP_CNT_EN to include the CNT cycle counter and CNT_CTL;
// otherwise both addresses behave as unmapped.
module perip_bridge
  import perip_bridge_pkg::*;
#(
  parameter int DRAM_AW  = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  perip_bridge_if.slave        bus,
  input  logic [23:0]          sw,
  output logic [23:0]          led,
  output logic [7:0]           seg_an,
  output logic [7:0]           seg_cx
);

  logic [31:0]        dram [2**DRAM_AW];
  logic [31:0]        seg_reg;
  logic [31:0]        word_addr;
  logic [DRAM_AW-1:0] dram_idx;
  logic               dram_hit;
  logic [3:0]         lanes;
  logic [31:0]        wd;
  logic               word_we;

  // DRAM base is aligned to its size, so a high-bit compare is the range check.
  assign dram_hit  = (bus.perip_addr[31:DRAM_AW+2] == DRAM_BASE[31:DRAM_AW+2]);
  assign dram_idx  = bus.perip_addr[DRAM_AW+1:2];
  assign word_addr = {bus.perip_addr[31:2], 2'b00};
  assign lanes     = store_lanes(mask_e'(bus.perip_mask), bus.perip_addr[1:0]);
  assign wd        = store_data(mask_e'(bus.perip_mask), bus.perip_wdata);
  // All four lanes enabled only for an aligned word store: MMIO accepts nothing else.
  assign word_we   = bus.perip_wen && (lanes == 4'hF) && !rst_n;

  // Reset also blocks RAM writes so a store coincident with reset has no effect.
  always_ff @(posedge clk) begin
    if (bus.perip_wen && dram_hit && !rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) dram[dram_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      led     <= '0;
      seg_reg <= '0;
    end else if (word_we) begin
      if (word_addr == LED_ADDR) led     <= bus.perip_wdata[23:0];
      if (word_addr == SEG_ADDR) seg_reg <= bus.perip_wdata;
    end
  end

`ifdef PERIP_CNT_EN
  logic [31:0] cnt;
  logic        cnt_run;

  // A start command restarts from 0 even when already running; stop holds
  // the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt     <= '0;
      cnt_run <= 1'b0;
    end else if (word_we && word_addr == CTL_ADDR && bus.perip_wdata == CNT_CMD_START) begin
      cnt     <= '0;
      cnt_run <= 1'b1;
    end else if (word_we && word_addr == CTL_ADDR && bus.perip_wdata == CNT_CMD_STOP) begin
      cnt_run <= 1'b0;
    end else if (cnt_run) begin
      cnt <= cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    bus.perip_rdata = '0;
    if (dram_hit) begin
      bus.perip_rdata = dram[dram_idx];
    end else begin
      case (word_addr)
        SW_ADDR:  bus.perip_rdata = {8'b0, sw};
        SEG_ADDR: bus.perip_rdata = seg_reg;
        LED_ADDR: bus.perip_rdata = {8'b0, led};
`ifdef PERIP_CNT_EN
        CNT_ADDR: bus.perip_rdata = cnt;
`endif
        default:  bus.perip_rdata = '0;
      endcase
    end
  end

  perip_bridge_seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_val (seg_reg),
    .seg_an  (seg_an),
    .seg_cx  (seg_cx)
  );

endmodule

// File: tb/tb_perip_bridge.sv
// tb_perip_bridge: scoreboard bench for perip_bridge (SCAN_DIV = 4).
module tb_perip_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cx;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  perip_bridge_if bus();

  perip_bridge #(.DRAM_AW(14), .SCAN_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sw     (sw),
    .led    (led),
    .seg_an (seg_an),
    .seg_cx (seg_cx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mask);
    bus.perip_addr  = addr;
    bus.perip_wdata = data;
    bus.perip_mask  = mask;
    bus.perip_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.perip_wen   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.perip_addr = addr;
    exp_q.push_back(exp);
    #1;
    check(tag, bus.perip_rdata, exp_q.pop_front());
  endtask

  logic [31:0] cnt_exp;
  logic [31:0] seg_word;
  logic [7:0]  prev_an;
  bit          found;

  initial begin
    bus.perip_addr  = '0;
    bus.perip_wdata = '0;
    bus.perip_mask  = 2'b10;
    bus.perip_wen   = 1'b0;
    sw    = 24'hA5A5A5;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    // Reset state
    rd("sw_read", 32'h8020_0000, 32'h00A5_A5A5);
    check("led_rst", {8'b0, led}, 32'h0);
    check("an_rst", {24'b0, seg_an}, 32'hFE);
    check("cx_rst", {24'b0, seg_cx}, 32'hC0);
    rd("seg_rst", 32'h8020_0020, 32'h0);

    // DRAM lane steering
    wr(32'h8010_0010, 32'h1122_3344, 2'b10);
    rd("dram_word", 32'h8010_0010, 32'h1122_3344);
    wr(32'h8010_0011, 32'h0000_00EE, 2'b00);
    rd("dram_byte", 32'h8010_0010, 32'h1122_EE44);
    wr(32'h8010_0012, 32'h0000_BEEF, 2'b01);
    rd("dram_half", 32'h8010_0013, 32'hBEEF_EE44);

    // Misaligned / reserved stores dropped
    wr(32'h8010_0011, 32'h0000_1234, 2'b01);
    wr(32'h8010_0012, 32'hDEAD_BEEF, 2'b10);
    wr(32'h8010_0010, 32'h5555_5555, 2'b11);
    rd("dram_misal", 32'h8010_0010, 32'hBEEF_EE44);

    // Unmapped
    wr(32'h8030_0000, 32'h1234_5678, 2'b10);
    rd("unmapped", 32'h8030_0000, 32'h0);

    // Last DRAM word boundary, and one past it
    wr(32'h8010_FFFC, 32'hA1B2_C3D4, 2'b10);
    rd("dram_top", 32'h8010_FFFC, 32'hA1B2_C3D4);
    wr(32'h8011_0000, 32'h7777_7777, 2'b10);
    rd("dram_past", 32'h8011_0000, 32'h0);

    // Store and load same cycle: old value, then new
    bus.perip_addr  = 32'h8010_0010;
    bus.perip_wdata = 32'hCAFE_F00D;
    bus.perip_mask  = 2'b10;
    bus.perip_wen   = 1'b1;
    exp_q.push_back(32'hBEEF_EE44);
    #1 check("same_cyc_old", bus.perip_rdata, exp_q.pop_front());
    @(posedge clk); #1 bus.perip_wen = 1'b0;
    rd("same_cyc_new", 32'h8010_0010, 32'hCAFE_F00D);

    // LED: word only, upper bits dropped
    wr(32'h8020_0040, 32'h0000_00FF, 2'b00);
    wr(32'h8020_0040, 32'h0000_FFFF, 2'b01);
    rd("led_narrow", 32'h8020_0040, 32'h0);
    wr(32'h8020_0040, 32'hFFFF_FFFF, 2'b10);
    rd("led_word", 32'h8020_0040, 32'h00FF_FFFF);
    check("led_pin", {8'b0, led}, 32'h00FF_FFFF);

    // Cycle counter
    wr(32'h8020_0060, 32'h8000_0000, 2'b10);
    repeat (100) @(posedge clk);
    #1;
    wr(32'h8020_0060, 32'hFFFF_FFFF, 2'b10);
`ifdef PERIP_CNT_EN
    cnt_exp = 32'd100;
`else
    cnt_exp = 32'd0;
`endif
    rd("cnt_stop", 32'h8020_0050, cnt_exp);
    repeat (50) @(posedge clk);
    rd("cnt_hold", 32'h8020_0050, cnt_exp);
    rd("ctl_read", 32'h8020_0060, 32'h0);

    // Seven-segment scan
    seg_word = 32'h0123_4567;
    wr(32'h8020_0020, seg_word, 2'b10);
    rd("seg_read", 32'h8020_0020, seg_word);
    found   = 1'b0;
    prev_an = seg_an;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (prev_an == 8'h7F && seg_an == 8'hFE) found = 1'b1;
      prev_an = seg_an;
    end
    check("seg_sync", {31'b0, found}, 32'd1);
    if (found) begin
      for (int k = 0; k <= 32; k++) begin
        int d;
        d = (k / 4) % 8;
        exp_q.push_back({16'b0, ~(8'd1 << d), glyph(4'((seg_word >> (4 * d)) & 32'hF))});
      end
      for (int k = 0; k <= 32; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        check($sformatf("scan_%0d", k), {16'b0, seg_an, seg_cx}, exp_q.pop_front());
      end
    end

    // Reset overrides a concurrent LED store
    bus.perip_addr  = 32'h8020_0040;
    bus.perip_wdata = 32'h00FF_FFFF;
    bus.perip_mask  = 2'b10;
    bus.perip_wen   = 1'b1;
    rst_n           = 1'b1;
    @(posedge clk); #1;
    bus.perip_wen = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    check("led_rst_ovr", {8'b0, led}, 32'h0);
    rd("seg_rst_ovr", 32'h8020_0020, 32'h0);
    rd("cnt_rst_ovr", 32'h8020_0050, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
